// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : opcode constants, next-PC source encoding, opcode extraction
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int unsigned OPC_W = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_HALT = 4'h0;
  localparam opcode_t OPC_RETI = 4'h3;

  typedef enum logic [2:0] {
    PC_SRC_SEQ    = 3'd0,
    PC_SRC_HOLD   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_VEC    = 3'd3,
    PC_SRC_RETI   = 3'd4
  } pc_src_t;

  // Instructions up to 64 bits wide; the opcode is the top OPC_W bits of the instr_w-bit word.
  function automatic opcode_t opcode_of(input logic [63:0] instr, input int unsigned instr_w);
    logic [63:0] shifted;
    shifted = instr >> (instr_w - OPC_W);
    return opcode_t'(shifted);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_irq_unit_if.sv
// ============================================================================
// fetch_irq_unit_if : imem, pipeline-control and interrupt signals of the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_irq_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int NUM_IRQ = 4
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus1;
  logic               jorb;
  logic [PC_W-1:0]    new_pc;
  logic               ld_stall;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] int_ack;
  logic               in_service;
  logic               halted;

  modport master (
    output imem_addr, instr, pc, pc_plus1, int_ack, in_service, halted,
    input  imem_rdata, jorb, new_pc, ld_stall, irq, irq_en
  );

  modport slave (
    input  imem_addr, instr, pc, pc_plus1, int_ack, in_service, halted,
    output imem_rdata, jorb, new_pc, ld_stall, irq, irq_en
  );

endinterface

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// irq_arbiter : rising-edge capture, pending/mask, fixed priority (channel 0 highest)
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_arbiter #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [NUM_IRQ-1:0] irq,
  input  wire logic [NUM_IRQ-1:0] irq_en,
  input  wire logic [NUM_IRQ-1:0] grant,
  output logic                    req_valid,
  output logic [IDX_W-1:0]        req_idx
);

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_active;

  assign w_rise   = irq & ~r_irq_prev;
  assign w_active = r_pending & irq_en;

  // A fresh edge in the grant cycle survives the clear, so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
    end else begin
      r_irq_prev <= irq;
      r_pending  <= (r_pending & ~grant) | w_rise;
    end
  end

  always_comb begin
    req_valid = 1'b0;
    req_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        req_valid = 1'b1;
        req_idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_irq_unit.sv
// ============================================================================
// fetch_irq_unit : PC register, next-PC selection and vectored interrupt entry/return
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_irq_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W       = 16,
  parameter int              INSTR_W    = 16,
  parameter int              NUM_IRQ    = 4,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(5),
  parameter int unsigned     VEC_STRIDE = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  fetch_irq_unit_if.master bus
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SVC = 1'b1;

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_saved_pc;
  logic [NUM_IRQ-1:0] r_int_ack;
  logic [0:0]         r_state;
  logic [0:0]         w_state_next;

  logic [PC_W-1:0]    w_pc_plus1;
  logic [PC_W-1:0]    w_vec_addr;
  logic [PC_W-1:0]    w_next_pc;
  opcode_t            w_opc;
  logic               w_is_halt;
  logic               w_is_reti;
  logic               w_in_service;
  logic               w_req_valid;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_take_irq;
  pc_src_t            w_pc_src;

  irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .irq       (bus.irq),
    .irq_en    (bus.irq_en),
    .grant     (r_int_ack),
    .req_valid (w_req_valid),
    .req_idx   (w_req_idx)
  );

  assign w_opc      = opcode_of(64'(bus.imem_rdata), INSTR_W);
  assign w_is_halt  = (w_opc == OPC_HALT);
  assign w_is_reti  = (w_opc == OPC_RETI);
  assign w_pc_plus1 = r_pc + PC_W'(1);
  assign w_vec_addr = VEC_BASE + PC_W'(VEC_STRIDE * 32'(w_req_idx));

  // Branches and stalls defer entry so a taken branch target is never overwritten.
  assign w_take_irq = ~w_in_service & ~bus.jorb & ~bus.ld_stall & w_req_valid;

  always_comb begin
    w_pc_src = PC_SRC_SEQ;
    if (w_is_reti && w_in_service)     w_pc_src = PC_SRC_RETI;
    else if (w_take_irq)               w_pc_src = PC_SRC_VEC;
    else if (bus.jorb)                 w_pc_src = PC_SRC_BRANCH;
    else if (w_is_halt || bus.ld_stall) w_pc_src = PC_SRC_HOLD;
  end

  always_comb begin
    w_next_pc = w_pc_plus1;
    case (w_pc_src)
      PC_SRC_RETI:   w_next_pc = r_saved_pc;
      PC_SRC_VEC:    w_next_pc = w_vec_addr;
      PC_SRC_BRANCH: w_next_pc = bus.new_pc;
      PC_SRC_HOLD:   w_next_pc = r_pc;
      default:       w_next_pc = w_pc_plus1;
    endcase
  end

  // Handler-tracking state machine: register, next state, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_take_irq) w_state_next = ST_SVC;
      ST_SVC:  if (w_is_reti)  w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_in_service = (r_state == ST_SVC);
  end

  // A HALT interrupted in place resumes after itself, otherwise the interrupted PC re-executes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_saved_pc <= '0;
      r_int_ack  <= '0;
    end else begin
      r_pc      <= w_next_pc;
      r_int_ack <= w_take_irq ? (NUM_IRQ'(1) << w_req_idx) : '0;
      if (w_take_irq)
        r_saved_pc <= w_is_halt ? w_pc_plus1 : r_pc;
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.pc         = r_pc;
  assign bus.pc_plus1   = w_pc_plus1;
  assign bus.instr      = bus.imem_rdata;
  assign bus.int_ack    = r_int_ack;
  assign bus.in_service = w_in_service;
  assign bus.halted     = w_is_halt & ~w_take_irq;

endmodule

`default_nettype wire

// File: tb/tb_fetch_irq_unit.sv
// ============================================================================
// tb_fetch_irq_unit : scoreboard bench with a cycle-level reference model of fetch_irq_unit
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_irq_unit;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int NUM_IRQ = 4;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_NOP  = 4'h1;
  localparam logic [3:0] OP_RETI = 4'h3;
  localparam logic [3:0] ALL_EN  = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_irq_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NUM_IRQ(NUM_IRQ)) bus ();

  fetch_irq_unit #(
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .NUM_IRQ    (NUM_IRQ),
    .RESET_VEC  (16'h0000),
    .VEC_BASE   (16'h0005),
    .VEC_STRIDE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pp1;
    logic [15:0] instr;
    logic [3:0]  ack;
    logic        svc;
    logic        halt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers and per-channel bits.
  int m_pc;
  int m_saved;
  bit m_svc;
  int m_ack_ch;
  bit m_pend[NUM_IRQ];
  bit m_prev[NUM_IRQ];

  task automatic model_reset();
    m_pc = 0; m_saved = 0; m_svc = 0; m_ack_ch = -1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // One clock cycle: drive inputs, record the model's expected outputs, advance the model.
  task automatic step(input logic [3:0] opc, input logic j, input logic [15:0] tgt,
                      input logic st, input logic [3:0] rq, input logic [3:0] en, input logic r);
    exp_t e;
    int   sel;
    bit   take, is_halt, is_reti, rise;
    int   npc;
    logic [15:0] word;
    @(posedge clk);
    #1;
    word = {opc, 12'($urandom)};
    rst = r;
    bus.imem_rdata = word;
    bus.jorb = j;
    bus.new_pc = tgt;
    bus.ld_stall = st;
    bus.irq = rq;
    bus.irq_en = en;
    if (r) model_reset();
    sel = -1;
    for (int i = 0; i < NUM_IRQ; i++)
      if (sel < 0 && m_pend[i] && en[i]) sel = i;
    take    = !r && !m_svc && !j && !st && (sel >= 0);
    is_halt = (opc == OP_HALT);
    is_reti = (opc == OP_RETI);
    e.pc    = 16'(m_pc);
    e.pp1   = 16'((m_pc + 1) % 65536);
    e.instr = word;
    e.ack   = (m_ack_ch >= 0) ? 4'(1 << m_ack_ch) : 4'h0;
    e.svc   = m_svc;
    e.halt  = is_halt && !take;
    q.push_back(e);
    if (!r) begin
      if (is_reti && m_svc)     npc = m_saved;
      else if (take)            npc = 5 + sel * 4;
      else if (j)               npc = int'(tgt);
      else if (is_halt || st)   npc = m_pc;
      else                      npc = m_pc + 1;
      if (take) m_saved = is_halt ? (m_pc + 1) % 65536 : m_pc;
      for (int i = 0; i < NUM_IRQ; i++) begin
        rise = rq[i] && !m_prev[i];
        m_pend[i] = rise || (m_pend[i] && (m_ack_ch != i));
        m_prev[i] = rq[i];
      end
      if (take) m_svc = 1;
      else if (is_reti && m_svc) m_svc = 0;
      m_ack_ch = take ? sel : -1;
      m_pc = npc % 65536;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("pc",         bus.pc,               e.pc);
        cmp("imem_addr",  bus.imem_addr,        e.pc);
        cmp("pc_plus1",   bus.pc_plus1,         e.pp1);
        cmp("instr",      bus.instr,            e.instr);
        cmp("int_ack",    16'(bus.int_ack),     16'(e.ack));
        cmp("in_service", 16'(bus.in_service),  16'(e.svc));
        cmp("halted",     16'(bus.halted),      16'(e.halt));
      end
    end
  end

  initial begin : driver
    logic [3:0] rq, en, opc;
    logic       j, st, r;
    int         pick;
    bus.imem_rdata = '0; bus.jorb = 1'b0; bus.new_pc = '0; bus.ld_stall = 1'b0;
    bus.irq = '0; bus.irq_en = '0;
    model_reset();

    // Reset, then free-running NOPs.
    repeat (2) step(OP_NOP, 0, 16'h0, 0, 4'h0, ALL_EN, 1);
    repeat (4) step(OP_NOP, 0, 16'h0, 0, 4'h0, ALL_EN, 0);

    // Single interrupt on channel 2 taken at pc 0x0010, RETI back.
    step(OP_NOP,  1, 16'h0010, 0, 4'b0100, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0100, ALL_EN, 0);
    step(OP_RETI, 0, 16'h0,    0, 4'b0100, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0000, ALL_EN, 0);

    // Priority and mask: ch3 enabled alone, then retained ch1 once unmasked.
    step(OP_NOP,  0, 16'h0, 0, 4'b1010, 4'b1000, 0);
    step(OP_NOP,  0, 16'h0, 0, 4'b1010, 4'b1000, 0);
    step(OP_RETI, 0, 16'h0, 0, 4'b1010, 4'b1000, 0);
    step(OP_NOP,  0, 16'h0, 0, 4'b1010, 4'b1111, 0);
    step(OP_RETI, 0, 16'h0, 0, 4'b1010, 4'b1111, 0);
    step(OP_NOP,  0, 16'h0, 0, 4'b0000, 4'b1111, 0);

    // Edge collides with a branch, then with a two-cycle load stall.
    step(OP_NOP,  1, 16'h0040, 0, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0001, ALL_EN, 0);
    step(OP_RETI, 0, 16'h0,    0, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0000, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    1, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    1, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0001, ALL_EN, 0);
    step(OP_RETI, 0, 16'h0,    0, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0,    0, 4'b0000, ALL_EN, 0);

    // Halt at 0x0020, woken by channel 0, RETI resumes at 0x0021.
    step(OP_NOP,  1, 16'h0020, 0, 4'b0000, ALL_EN, 0);
    repeat (5) step(OP_HALT, 0, 16'h0, 0, 4'b0000, ALL_EN, 0);
    step(OP_HALT, 0, 16'h0, 0, 4'b0001, ALL_EN, 0);
    step(OP_HALT, 0, 16'h0, 0, 4'b0001, ALL_EN, 0);
    step(OP_RETI, 0, 16'h0, 0, 4'b0001, ALL_EN, 0);
    step(OP_NOP,  0, 16'h0, 0, 4'b0000, ALL_EN, 0);

    // RETI outside a handler, then PC wrap.
    repeat (2) step(OP_RETI, 0, 16'h0, 0, 4'b0000, ALL_EN, 0);
    step(OP_NOP, 1, 16'hFFFF, 0, 4'b0000, ALL_EN, 0);
    repeat (2) step(OP_NOP, 0, 16'h0, 0, 4'b0000, ALL_EN, 0);

    // Reset asserted while a handler is running.
    step(OP_NOP, 0, 16'h0, 0, 4'b0010, ALL_EN, 0);
    step(OP_NOP, 0, 16'h0, 0, 4'b0010, ALL_EN, 0);
    step(OP_NOP, 0, 16'h0, 0, 4'b0010, ALL_EN, 0);
    step(OP_NOP, 0, 16'h0, 0, 4'b0010, ALL_EN, 1);
    step(OP_NOP, 0, 16'h0, 0, 4'b0000, ALL_EN, 0);

    // Randomised traffic.
    rq = '0;
    en = ALL_EN;
    for (int n = 0; n < 800; n++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 5)       opc = OP_HALT;
      else if (pick < 20) opc = OP_RETI;
      else if (pick < 30) opc = OP_NOP;
      else                opc = 4'($urandom_range(4, 15));
      j  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_IRQ; i++)
        if ($urandom_range(0, 4) == 0) rq[i] = ~rq[i];
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      step(opc, j, 16'($urandom), st, rq, en, r);
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
